// File: rtl/codec_protocol_checker.sv
// Runtime checker for a fixed-latency codec port. It flags missing or
// spurious outputs and key changes while work is in flight. Results are
// reported as registered pulses, sticky status and saturating counters.
module codec_protocol_checker #(
    parameter int KEY_W     = 64,
    parameter int LATENCY   = 17,
    parameter int CNT_W     = 16,
    parameter bit CHECK_KEY = 1'b1,
    parameter int ID        = 0,
    localparam int IW       = $clog2(LATENCY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clr,
    input  logic             valid_i,
    input  logic [KEY_W-1:0] key,
    input  logic             valid_o,
    output logic [7:0]       chk_id,
    output logic [2:0]       err_pulse,
    output logic [2:0]       err_status,
    output logic [2:0]       first_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] txn_in_cnt,
    output logic [CNT_W-1:0] txn_out_cnt,
    output logic [IW-1:0]    inflight
);

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [LATENCY-1:0] pipe;
    logic [LATENCY-1:0] pipe_next;
    logic               accept;
    logic               exp;
    logic               missing;
    logic               spurious;
    logic               key_err;
    logic               matched;

    assign chk_id   = 8'(ID);
    assign accept   = valid_i & enable;
    assign exp      = pipe[LATENCY-1];
    assign missing  = exp & ~valid_o;
    assign spurious = valid_o & ~exp & enable;
    assign matched  = exp & valid_o;

    // Shift the accept bit in; a one-stage pipe just holds the accept bit.
    generate
        if (LATENCY == 1) begin : g_pipe_one
            assign pipe_next = accept;
        end else begin : g_pipe_many
            assign pipe_next = {pipe[LATENCY-2:0], accept};
        end
    endgenerate

    // Key stability: compare against last cycle's key while work is in flight.
    generate
        if (CHECK_KEY) begin : g_key
            logic [KEY_W-1:0] key_q;

            // Remember the key seen at the previous edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) key_q <= '0;
                else        key_q <= key;
            end

            assign key_err = (inflight != '0) && (key != key_q);
        end else begin : g_no_key
            assign key_err = 1'b0;
        end
    endgenerate

    // Expectation pipe and in-flight count; clr deliberately leaves these alone.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state uses non-blocking assignments so every register
        // reacts to the values present before the edge, not to each other.
        if (!rst_n) begin
            pipe     <= '0;
            inflight <= '0;
        end else begin
            pipe <= pipe_next;
            case ({accept, exp})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // One-cycle error pulses: [0] missing, [1] spurious, [2] key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_pulse <= '0;
        else        err_pulse <= {key_err, spurious, missing};
    end

    // Sticky status and counters; a pulse present during clr survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_status  <= '0;
            first_err   <= '0;
            err_cnt     <= '0;
            txn_in_cnt  <= '0;
            txn_out_cnt <= '0;
        end else if (clr) begin
            // NOTE: clr restarts bookkeeping from the current pulse, so an
            // error in the clearing cycle is kept rather than dropped.
            err_status  <= err_pulse;
            first_err   <= err_pulse;
            err_cnt     <= (err_pulse != '0) ? CNT_W'(1) : '0;
            txn_in_cnt  <= '0;
            txn_out_cnt <= '0;
        end else begin
            err_status <= err_status | err_pulse;
            if (first_err == '0) first_err <= err_pulse;
            if (err_pulse != '0) err_cnt <= sat_inc(err_cnt);
            if (accept)          txn_in_cnt <= sat_inc(txn_in_cnt);
            if (matched)         txn_out_cnt <= sat_inc(txn_out_cnt);
        end
    end

endmodule

// File: tb/tb_codec_protocol_checker.sv
// Directed bench for codec_protocol_checker. Expected error pulses go into a
// scoreboard queue; a monitor pops and compares whenever a pulse appears.
module tb_codec_protocol_checker;

    localparam int KW  = 64;
    localparam int LAT = 17;
    localparam int IW  = $clog2(LAT + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          clr = 1'b0;
    logic          valid_i = 1'b0;
    logic          valid_o = 1'b0;
    logic [KW-1:0] key = '0;

    // main instance
    logic [7:0]    chk_id_a;
    logic [2:0]    err_pulse_a, err_status_a, first_err_a;
    logic [15:0]   err_cnt_a, txn_in_a, txn_out_a;
    logic [IW-1:0] inflight_a;
    // key check disabled
    logic [7:0]    chk_id_b;
    logic [2:0]    err_pulse_b, err_status_b, first_err_b;
    logic [15:0]   err_cnt_b, txn_in_b, txn_out_b;
    logic [IW-1:0] inflight_b;
    // 4-bit counters
    logic [7:0]    chk_id_c;
    logic [2:0]    err_pulse_c, err_status_c, first_err_c;
    logic [3:0]    err_cnt_c, txn_in_c, txn_out_c;
    logic [IW-1:0] inflight_c;

    codec_protocol_checker #(.KEY_W(KW), .LATENCY(LAT), .CNT_W(16), .CHECK_KEY(1'b1), .ID(8'h5A)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .valid_i(valid_i), .key(key),
        .valid_o(valid_o), .chk_id(chk_id_a), .err_pulse(err_pulse_a), .err_status(err_status_a),
        .first_err(first_err_a), .err_cnt(err_cnt_a), .txn_in_cnt(txn_in_a),
        .txn_out_cnt(txn_out_a), .inflight(inflight_a));

    codec_protocol_checker #(.KEY_W(KW), .LATENCY(LAT), .CNT_W(16), .CHECK_KEY(1'b0), .ID(1)) dut_nk (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .valid_i(valid_i), .key(key),
        .valid_o(valid_o), .chk_id(chk_id_b), .err_pulse(err_pulse_b), .err_status(err_status_b),
        .first_err(first_err_b), .err_cnt(err_cnt_b), .txn_in_cnt(txn_in_b),
        .txn_out_cnt(txn_out_b), .inflight(inflight_b));

    codec_protocol_checker #(.KEY_W(KW), .LATENCY(LAT), .CNT_W(4), .CHECK_KEY(1'b1), .ID(2)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .valid_i(valid_i), .key(key),
        .valid_o(valid_o), .chk_id(chk_id_c), .err_pulse(err_pulse_c), .err_status(err_status_c),
        .first_err(first_err_c), .err_cnt(err_cnt_c), .txn_in_cnt(txn_in_c),
        .txn_out_cnt(txn_out_c), .inflight(inflight_c));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int       at;
        logic [2:0] val;
    } exp_t;
    exp_t pq[$];

    // Pulse monitor: every nonzero err_pulse must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (err_pulse_a != 3'b000) begin
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL pulse_unexpected edge=%0d got=%b want=none", edge_n, err_pulse_a);
                end else begin
                    e = pq.pop_front();
                    if (e.at != edge_n || e.val != err_pulse_a) begin
                        errors++;
                        $display("FAIL pulse edge=%0d got=%b want=%b at edge %0d",
                                 edge_n, err_pulse_a, e.val, e.at);
                    end
                end
            end else if (pq.size() != 0 && pq[0].at <= edge_n) begin
                checks++;
                errors++;
                e = pq.pop_front();
                $display("FAIL pulse_absent edge=%0d got=000 want=%b", edge_n, e.val);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Per-test stimulus plan, indexed by edge number relative to base.
    int            base;
    bit            vi_at[64];
    bit            vo_at[64];
    int            key_rel;
    logic [KW-1:0] key_new;
    int            en_off_rel;
    int            clr_rel;

    task automatic start_test();
        enable  = 1'b1;
        clr     = 1'b0;
        valid_i = 1'b0;
        valid_o = 1'b0;
        rst_n   = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        base = edge_n;
        for (int i = 0; i < 64; i++) begin
            vi_at[i] = 1'b0;
            vo_at[i] = 1'b0;
        end
        key_rel    = -1;
        key_new    = key;
        en_off_rel = 1000;
        clr_rel    = -1;
    endtask

    task automatic expect_pulse(input int rel, input logic [2:0] v);
        pq.push_back('{base + rel, v});
    endtask

    // Drive the plan for relative edges from..to inclusive.
    task automatic play(input int from, input int to);
        for (int r = from; r <= to; r++) begin
            valid_i = vi_at[r];
            valid_o = vo_at[r];
            enable  = (r < en_off_rel);
            clr     = (r == clr_rel);
            if (r == key_rel) key = key_new;
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        valid_o = 1'b0;
        clr     = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pulse",    err_pulse_a,  0);
        check("rst_status",   err_status_a, 0);
        check("rst_first",    first_err_a,  0);
        check("rst_err_cnt",  err_cnt_a,    0);
        check("rst_txn_in",   txn_in_a,     0);
        check("rst_txn_out",  txn_out_a,    0);
        check("rst_inflight", inflight_a,   0);
        check("rst_chk_id",   chk_id_a,     8'h5A);

        // Correctly timed output, with a legal key change on the accepting edge
        start_test();
        vi_at[1] = 1'b1;
        vo_at[18] = 1'b1;
        key_rel = 1;
        key_new = 64'hDEAD_BEEF_0123_4567;
        play(1, 1);
        check("t1_inflight_start", inflight_a, 1);
        play(2, 17);
        check("t1_inflight_hold", inflight_a, 1);
        play(18, 18);
        check("t1_inflight_end", inflight_a, 0);
        check("t1_txn_in", txn_in_a, 1);
        check("t1_txn_out", txn_out_a, 1);
        play(19, 20);
        check("t1_status", err_status_a, 0);
        check("t1_err_cnt", err_cnt_a, 0);

        // Output one cycle early: spurious, then missing
        start_test();
        vi_at[1] = 1'b1;
        vo_at[17] = 1'b1;
        expect_pulse(17, 3'b010);
        expect_pulse(18, 3'b001);
        play(1, 21);
        check("t2_status", err_status_a, 3'b011);
        check("t2_first", first_err_a, 3'b010);
        check("t2_err_cnt", err_cnt_a, 2);
        check("t2_txn_out", txn_out_a, 0);

        // Key change while in flight; the CHECK_KEY=0 instance must stay quiet
        start_test();
        vi_at[1] = 1'b1;
        vo_at[18] = 1'b1;
        key_rel = 6;
        key_new = key ^ 64'h0000_0000_0000_0100;
        expect_pulse(6, 3'b100);
        play(1, 20);
        check("t3_status", err_status_a, 3'b100);
        check("t3_err_cnt", err_cnt_a, 1);
        check("t3_txn_out", txn_out_a, 1);
        check("t3_nk_status", err_status_b, 0);
        check("t3_nk_err_cnt", err_cnt_b, 0);
        check("t3_nk_txn_out", txn_out_b, 1);

        // 20 back-to-back transactions, then clr alongside a missing error
        start_test();
        for (int i = 1; i <= 20; i++) begin
            vi_at[i] = 1'b1;
            vo_at[i + 17] = 1'b1;
        end
        play(1, 17);
        check("t4_inflight_peak", inflight_a, 17);
        play(18, 20);
        check("t4_inflight_steady", inflight_a, 17);
        play(21, 37);
        check("t4_inflight_drain", inflight_a, 0);
        check("t4_txn_in", txn_in_a, 20);
        check("t4_txn_out", txn_out_a, 20);
        check("t4_status", err_status_a, 0);
        check("t4_c4_txn_in_sat", txn_in_c, 15);
        check("t4_c4_txn_out_sat", txn_out_c, 15);
        vi_at[40] = 1'b1;
        clr_rel = 58;
        expect_pulse(57, 3'b001);
        play(38, 60);
        check("t5_c4_status", err_status_c, 3'b001);
        check("t5_c4_first", first_err_c, 3'b001);
        check("t5_c4_err_cnt", err_cnt_c, 1);
        check("t5_c4_txn_in", txn_in_c, 0);
        check("t5_c4_txn_out", txn_out_c, 0);

        // Reset mid-flight: the lost transaction is never reported
        start_test();
        vi_at[1] = 1'b1;
        play(1, 4);
        rst_n = 1'b0;
        play(5, 6);
        rst_n = 1'b1;
        play(7, 25);
        check("t6_pulse", err_pulse_a, 0);
        check("t6_status", err_status_a, 0);
        check("t6_err_cnt", err_cnt_a, 0);
        check("t6_txn_in", txn_in_a, 0);
        check("t6_inflight", inflight_a, 0);

        // enable low: new inputs and spurious outputs ignored, missing still caught
        start_test();
        vi_at[1] = 1'b1;
        en_off_rel = 2;
        vi_at[3] = 1'b1;
        vo_at[5] = 1'b1;
        expect_pulse(18, 3'b001);
        play(1, 22);
        check("t7_txn_in", txn_in_a, 1);
        check("t7_status", err_status_a, 3'b001);
        check("t7_inflight", inflight_a, 0);

        check("pulse_queue_empty", pq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
